// File: rtl/lockin_pkg.sv
// Shared types and helpers for the lock-in amplifier datapath.
package lockin_pkg;

  localparam logic MODE_HALF = 1'b0;
  localparam logic MODE_FULL = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } demod_state_t;

  // Result packs {sum[63:0], clamped}; callers cast down to their width.
  function automatic logic [64:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    logic signed [63:0] val;
    logic               clamp;
    sum   = $signed({a[63], a}) + $signed({b[63], b});
    hi    = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo    = -(65'sd1 <<< (w - 1));
    val   = sum[63:0];
    clamp = 1'b0;
    if (sum > hi) begin
      val   = hi[63:0];
      clamp = 1'b1;
    end else if (sum < lo) begin
      val   = lo[63:0];
      clamp = 1'b1;
    end
    return {val, clamp};
  endfunction

endpackage

// File: rtl/synchro_demodulator_if.sv
// Sample/control/result bundle of the synchro demodulator.
interface synchro_demodulator_if #(
  parameter int DATA_W = 14,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);

  logic                     en;
  logic                     mode_full;
  logic                     chopper_sig;
  logic signed [DATA_W-1:0] in_sig;
  logic signed [DATA_W:0]   mix_out;
  logic signed [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]         samp_cnt;
  logic                     ovf_out;
  logic                     out_valid;

  modport master (
    output en, mode_full, chopper_sig, in_sig,
    input  mix_out, acc_out, samp_cnt, ovf_out, out_valid
  );

  modport slave (
    input  en, mode_full, chopper_sig, in_sig,
    output mix_out, acc_out, samp_cnt, ovf_out, out_valid
  );

endinterface

// File: rtl/chopper_edge_detect.sv
// Chopper level alignment and rising-edge detect.
// SYNCHRO_DEMOD_CHOPPER_SYNC_EN adds a 2-flop input synchroniser.
module chopper_edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic chop_in,
  output logic chop_o,
  output logic rise_o
);

`ifdef SYNCHRO_DEMOD_CHOPPER_SYNC_EN
  logic [1:0] sync_d;
  logic [1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[0], chop_in};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign chop_o = sync_q[1];
`else
  assign chop_o = chop_in;
`endif

  // lvl follows the mix register, prev one cycle behind it
  logic lvl_d, lvl_q;
  logic prev_d, prev_q;

  always_comb begin
    lvl_d  = chop_o;
    prev_d = lvl_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = lvl_q & ~prev_q;

endmodule

// File: rtl/synchro_demodulator.sv
// Phase-sensitive mixer plus per-frame saturating integrator.
// SYNCHRO_DEMOD_CHOPPER_SYNC_EN synchronises the chopper and delays in_sig.
module synchro_demodulator
  import lockin_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int ACC_W     = 32,
  parameter int N_PERIODS = 4,
  parameter int CNT_W     = 16
) (
  input logic                  clk_in,
  input logic                  rst_in,
  synchro_demodulator_if.slave bus
);

  localparam int PER_W = (N_PERIODS > 1) ? $clog2(N_PERIODS) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(N_PERIODS - 1);
  localparam int EXT_W = ACC_W - DATA_W - 1;

  logic                     chop;
  logic                     rise;
  logic signed [DATA_W-1:0] samp;
  logic signed [DATA_W:0]   in_ext;
  logic signed [DATA_W:0]   mix_d, mix_q;
  logic signed [ACC_W-1:0]  mix_ext;
  logic [ACC_W:0]           sum_pk;
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic signed [ACC_W-1:0]  acc_out_d, acc_out_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q, cnt_inc;
  logic [CNT_W-1:0]         samp_cnt_d, samp_cnt_q;
  logic [PER_W-1:0]         per_d, per_q;
  logic                     ovf_d, ovf_q;
  logic                     ovf_out_d, ovf_out_q;
  logic                     vld_d, vld_q;
  demod_state_t             state_d, state_q;

  chopper_edge_detect u_edge (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .chop_in(bus.chopper_sig),
    .chop_o (chop),
    .rise_o (rise)
  );

`ifdef SYNCHRO_DEMOD_CHOPPER_SYNC_EN
  logic signed [DATA_W-1:0] dly1_d, dly1_q;
  logic signed [DATA_W-1:0] dly2_d, dly2_q;

  always_comb begin
    dly1_d = bus.in_sig;
    dly2_d = dly1_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dly1_q <= '0;
      dly2_q <= '0;
    end else begin
      dly1_q <= dly1_d;
      dly2_q <= dly2_d;
    end
  end

  assign samp = dly2_q;
`else
  assign samp = bus.in_sig;
`endif

  // widen first so negating the most negative sample is exact
  always_comb begin
    in_ext = {samp[DATA_W-1], samp};
    mix_d  = '0;
    if (chop) begin
      mix_d = in_ext;
    end else if (bus.mode_full == MODE_FULL) begin
      mix_d = -in_ext;
    end
  end

  always_comb begin
    mix_ext = {{EXT_W{mix_q[DATA_W]}}, mix_q};
    sum_pk  = (ACC_W + 1)'(sat_add(64'(acc_q), 64'(mix_ext), ACC_W));
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    ovf_d      = ovf_q;
    acc_out_d  = acc_out_q;
    samp_cnt_d = samp_cnt_q;
    ovf_out_d  = ovf_out_q;
    vld_d      = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      per_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = RUN;
            acc_d   = mix_ext;
            cnt_d   = CNT_W'(1);
            per_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        RUN: begin
          if (rise && per_q == PER_LAST) begin
            acc_out_d  = acc_q;
            samp_cnt_d = cnt_q;
            ovf_out_d  = ovf_q;
            vld_d      = 1'b1;
            acc_d      = mix_ext;
            cnt_d      = CNT_W'(1);
            per_d      = '0;
            ovf_d      = 1'b0;
          end else begin
            acc_d = sum_pk[ACC_W:1];
            ovf_d = ovf_q | sum_pk[0];
            cnt_d = cnt_inc;
            if (rise) begin
              per_d = per_q + PER_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mix_q      <= '0;
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      per_q      <= '0;
      ovf_q      <= 1'b0;
      acc_out_q  <= '0;
      samp_cnt_q <= '0;
      ovf_out_q  <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      mix_q      <= mix_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      ovf_q      <= ovf_d;
      acc_out_q  <= acc_out_d;
      samp_cnt_q <= samp_cnt_d;
      ovf_out_q  <= ovf_out_d;
      vld_q      <= vld_d;
    end
  end

  assign bus.mix_out   = mix_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.samp_cnt  = samp_cnt_q;
  assign bus.ovf_out   = ovf_out_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_synchro_demodulator.sv
// Directed bench for synchro_demodulator: two instances share stimulus,
// A (32-bit acc, 2 periods/frame) and B (16-bit acc, 1 period/frame).
module tb_synchro_demodulator;

`ifdef SYNCHRO_DEMOD_CHOPPER_SYNC_EN
  localparam int MIX_LAT = 3;
  localparam int VLD_LAT = 4;
`else
  localparam int MIX_LAT = 1;
  localparam int VLD_LAT = 2;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              chop;
  logic              mode;
  logic              en_a;
  logic              en_b;
  logic signed [13:0] in_v;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_cyc = 0;

  int na = 0, a_cyc = 0, a_gap = 0, a_lat = 0;
  longint a_acc = 0, a_cnt = 0, a_ovf = 0;
  int nb = 0;
  longint b_acc = 0, b_cnt = 0, b_ovf = 0;

  always #5 clk_in = ~clk_in;

  synchro_demodulator_if #(.DATA_W(14), .ACC_W(32), .CNT_W(16)) ifa ();
  synchro_demodulator_if #(.DATA_W(14), .ACC_W(16), .CNT_W(16)) ifb ();

  assign ifa.en          = en_a;
  assign ifa.mode_full   = mode;
  assign ifa.chopper_sig = chop;
  assign ifa.in_sig      = in_v;
  assign ifb.en          = en_b;
  assign ifb.mode_full   = mode;
  assign ifb.chopper_sig = chop;
  assign ifb.in_sig      = in_v;

  synchro_demodulator #(
    .DATA_W(14), .ACC_W(32), .N_PERIODS(2), .CNT_W(16)
  ) dut_a (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (ifa.slave)
  );

  synchro_demodulator #(
    .DATA_W(14), .ACC_W(16), .N_PERIODS(1), .CNT_W(16)
  ) dut_b (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (ifb.slave)
  );

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (ifa.out_valid) begin
      na    <= na + 1;
      a_gap <= cyc - a_cyc;
      a_cyc <= cyc;
      a_lat <= cyc - rise_cyc;
      a_acc <= ifa.acc_out;
      a_cnt <= ifa.samp_cnt;
      a_ovf <= ifa.ovf_out;
    end
    if (ifb.out_valid) begin
      nb    <= nb + 1;
      b_acc <= ifb.acc_out;
      b_cnt <= ifb.samp_cnt;
      b_ovf <= ifb.ovf_out;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    chop = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (6) step();
  endtask

  task automatic close_frame();
    chop     = 1'b1;
    rise_cyc = cyc;
    step();
    chop = 1'b0;
    repeat (6) step();
  endtask

  task automatic run(input int per, input int hi, input int lo,
                     input int in_hi, input int in_lo,
                     input bit a_on, input bit b_on,
                     input int drop_at, input int rst_at);
    int k;
    k = 0;
    for (int p = 0; p < per; p++) begin
      for (int c = 0; c < hi + lo; c++) begin
        chop   = (c < hi);
        in_v   = (c < hi) ? 14'(in_hi) : 14'(in_lo);
        en_a   = a_on && (k != drop_at);
        en_b   = b_on;
        rst_in = (k == rst_at);
        if (c == 0) rise_cyc = cyc;
        step();
        if (k == rst_at) begin
          chk("rst_mid_acc", ifa.acc_out, 0);
          chk("rst_mid_cnt", ifa.samp_cnt, 0);
          chk("rst_mid_ovf", ifa.ovf_out, 0);
          chk("rst_mid_vld", ifa.out_valid, 0);
          chk("rst_mid_mix", ifa.mix_out, 0);
        end
        k++;
      end
    end
    rst_in = 1'b0;
  endtask

  initial begin
    int base;
    rst_in = 1'b1;
    chop   = 1'b0;
    mode   = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    in_v   = '0;
    repeat (3) step();
    chk("rst_acc", ifa.acc_out, 0);
    chk("rst_cnt", ifa.samp_cnt, 0);
    chk("rst_ovf", ifa.ovf_out, 0);
    chk("rst_vld", ifa.out_valid, 0);
    chk("rst_mix", ifa.mix_out, 0);
    chk("rst_acc_b", ifb.acc_out, 0);
    rst_in = 1'b0;

    // mixer corner values
    mode = 1'b1;
    in_v = -14'sd8192;
    chop = 1'b0;
    repeat (MIX_LAT + 2) step();
    chk("mix_neg_min", ifa.mix_out, 8192);
    chop = 1'b1;
    repeat (MIX_LAT + 2) step();
    chk("mix_pass_min", ifa.mix_out, -8192);
    mode = 1'b0;
    chop = 1'b0;
    repeat (MIX_LAT + 2) step();
    chk("mix_half_gate", ifa.mix_out, 0);
    chop = 1'b1;
    repeat (MIX_LAT + 2) step();
    in_v = 14'sd5;
    step();
    in_v = 14'sd7;
    repeat (MIX_LAT - 1) step();
    chk("mix_latency", ifa.mix_out, 5);
    step();
    chk("mix_next", ifa.mix_out, 7);
    idle();

    // half-wave DC
    mode = 1'b0;
    base = na;
    run(4, 4, 4, 100, 100, 1'b1, 1'b0, -1, -1);
    close_frame();
    chk("half_dumps", na - base, 2);
    chk("half_acc", a_acc, 800);
    chk("half_cnt", a_cnt, 16);
    chk("half_ovf", a_ovf, 0);
    chk("half_gap", a_gap, 16);
    chk("vld_latency", a_lat, VLD_LAT);
    idle();

    // full-wave DC
    mode = 1'b1;
    base = na;
    run(2, 4, 4, 100, 100, 1'b1, 1'b0, -1, -1);
    close_frame();
    chk("full_dc_dumps", na - base, 1);
    chk("full_dc_acc", a_acc, 0);
    chk("full_dc_cnt", a_cnt, 16);
    idle();

    // full-wave correlated
    base = na;
    run(2, 4, 4, 100, -100, 1'b1, 1'b0, -1, -1);
    close_frame();
    chk("full_corr_dumps", na - base, 1);
    chk("full_corr_acc", a_acc, 1600);
    idle();

    // enable drop inside the first frame
    mode = 1'b0;
    base = na;
    run(4, 4, 4, 100, 100, 1'b1, 1'b0, 13, -1);
    close_frame();
    chk("en_drop_dumps", na - base, 1);
    chk("en_drop_acc", a_acc, 800);
    chk("en_drop_cnt", a_cnt, 16);
    idle();

    // reset inside the first frame
    mode = 1'b1;
    base = na;
    run(4, 4, 4, 100, -100, 1'b1, 1'b0, -1, 13);
    close_frame();
    chk("rst_frame_dumps", na - base, 1);
    chk("rst_frame_acc", a_acc, 1600);
    chk("rst_frame_cnt", a_cnt, 16);
    idle();

    // saturation on the narrow instance
    mode = 1'b0;
    base = nb;
    run(1, 32, 32, 8191, 8191, 1'b0, 1'b1, -1, -1);
    run(1, 32, 32, 1, 1, 1'b0, 1'b1, -1, -1);
    chk("sat_dumps", nb - base, 1);
    chk("sat_acc", b_acc, 32767);
    chk("sat_ovf", b_ovf, 1);
    chk("sat_cnt", b_cnt, 64);
    close_frame();
    chk("clean_dumps", nb - base, 2);
    chk("clean_acc", b_acc, 32);
    chk("clean_ovf", b_ovf, 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
